cac_tx_sequencer: RTL and testbench

Controller for the 6-bit CAC coder (FNS/Fibonacci crosstalk-avoidance coder).
- After reset, generates the Fibonacci weight table FNS02..FNS06 sequentially and drives it to the coder.
- Accepts wide payload words through a valid/ready handshake and slices each word into BLEN-bit chunks.
- Issues one chunk per clock to the coder and flags the coder's registered codewords with valid/last, aligned to the coder's 1-cycle latency.
- Sits between the TSV/bus transmit logic and the CAC coder instance.

---
 rtl/cac_tx_sequencer_pkg.sv | 18 +
 rtl/cac_tx_sequencer_if.sv | 33 +++
 rtl/cac_fns_gen.sv | 71 +++++++
 rtl/cac_tx_sequencer.sv | 127 ++++++++++++
 tb/tb_cac_tx_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cac_tx_sequencer_pkg.sv
// Shared definitions for the CAC transmit sequencer: state encoding and
// Fibonacci/FNS constants for the 6-bit crosstalk-avoidance coder.
package cac_tx_sequencer_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam int FNS_INIT_STEPS = 4;
    localparam int FNS_STEP_W     = $clog2(FNS_INIT_STEPS);
    // F(8): number of distinct values a 6-bit FNS codeword can represent.
    localparam int F8             = 21;
    // Minimum weight width able to hold FNS06 = 8.
    localparam int FNSLEN_06      = 4;

endpackage

// File: rtl/cac_tx_sequencer_if.sv
// Payload handshake, coder-facing signals and status of the CAC transmit sequencer.
interface cac_tx_sequencer_if #(
    parameter int BLEN   = 4,
    parameter int CHUNKS = 4,
    parameter int FNSLEN = 5
);
    logic [CHUNKS*BLEN-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [BLEN-1:0]        coder_datain;
    logic [FNSLEN-1:0]      fns02;
    logic [FNSLEN-1:0]      fns03;
    logic [FNSLEN-1:0]      fns04;
    logic [FNSLEN-1:0]      fns05;
    logic [FNSLEN-1:0]      fns06;
    logic [5:0]             coder_codeout;
    logic [5:0]             code_out;
    logic                   code_valid;
    logic                   code_last;
    logic                   busy;

    modport master (
        input  in_data, in_valid, coder_codeout,
        output in_ready, coder_datain, fns02, fns03, fns04, fns05, fns06,
               code_out, code_valid, code_last, busy
    );

    modport slave (
        output in_data, in_valid, coder_codeout,
        input  in_ready, coder_datain, fns02, fns03, fns04, fns05, fns06,
               code_out, code_valid, code_last, busy
    );
endinterface

// File: rtl/cac_fns_gen.sv
// Generates the FNS weight table FNS03..FNS06 one entry per cycle after reset;
// done_o marks the cycle in which the last weight is written.
module cac_fns_gen
    import cac_tx_sequencer_pkg::*;
#(
    parameter int FNSLEN = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [FNSLEN-1:0] fns02_o,
    output logic [FNSLEN-1:0] fns03_o,
    output logic [FNSLEN-1:0] fns04_o,
    output logic [FNSLEN-1:0] fns05_o,
    output logic [FNSLEN-1:0] fns06_o,
    output logic              done_o
);
    localparam logic [FNSLEN-1:0]     FNS01     = FNSLEN'(1);
    localparam logic [FNS_STEP_W-1:0] STEP_LAST = FNS_STEP_W'(FNS_INIT_STEPS - 1);

    logic [FNS_STEP_W-1:0] step_q, step_d;
    logic                  run_q, run_d;
    logic [FNSLEN-1:0]     fns03_q, fns03_d;
    logic [FNSLEN-1:0]     fns04_q, fns04_d;
    logic [FNSLEN-1:0]     fns05_q, fns05_d;
    logic [FNSLEN-1:0]     fns06_q, fns06_d;

    always_comb begin
        step_d  = step_q;
        run_d   = run_q;
        fns03_d = fns03_q;
        fns04_d = fns04_q;
        fns05_d = fns05_q;
        fns06_d = fns06_q;
        if (run_q) begin
            unique case (step_q)
                2'd0:    fns03_d = fns02_o + FNS01;
                2'd1:    fns04_d = fns03_q + fns02_o;
                2'd2:    fns05_d = fns04_q + fns03_q;
                default: fns06_d = fns05_q + fns04_q;
            endcase
            step_d = step_q + FNS_STEP_W'(1);
            run_d  = (step_q != STEP_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_q  <= '0;
            run_q   <= 1'b1;
            fns03_q <= '0;
            fns04_q <= '0;
            fns05_q <= '0;
            fns06_q <= '0;
        end else begin
            step_q  <= step_d;
            run_q   <= run_d;
            fns03_q <= fns03_d;
            fns04_q <= fns04_d;
            fns05_q <= fns05_d;
            fns06_q <= fns06_d;
        end
    end

    assign fns02_o = FNSLEN'(1);
    assign fns03_o = fns03_q;
    assign fns04_o = fns04_q;
    assign fns05_o = fns05_q;
    assign fns06_o = fns06_q;
    assign done_o  = run_q && (step_q == STEP_LAST);

endmodule

// File: rtl/cac_tx_sequencer.sv
// Feeds the 6-bit CAC coder: builds its weight table, slices payload words into
// BLEN-bit chunks and flags the coder's registered codewords with valid/last.
module cac_tx_sequencer
    import cac_tx_sequencer_pkg::*;
#(
    parameter int BLEN   = 4,
    parameter int CHUNKS = 4,
    parameter int FNSLEN = 5
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    cac_tx_sequencer_if.master   bus
);
    localparam int            PW   = CHUNKS * BLEN;
    localparam int            IW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

    if ((1 << BLEN) > F8) begin : g_blen_check
        $error("BLEN too wide for a 6-bit FNS codeword");
    end
    if (FNSLEN < FNSLEN_06) begin : g_fnslen_check
        $error("FNSLEN too narrow for the FNS06 weight");
    end

    state_e            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic [BLEN-1:0]   datain_q, datain_d;
    logic [PW-1:0]     shreg_q, shreg_d;
    logic              issue_v_q, issue_v_d;
    logic              issue_last_q, issue_last_d;
    logic              code_valid_q, code_last_q;
    logic              in_ready;
    logic              fns_done;
    logic [FNSLEN-1:0] fns02, fns03, fns04, fns05, fns06;

    cac_fns_gen #(.FNSLEN(FNSLEN)) u_fns_gen (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .fns02_o (fns02),
        .fns03_o (fns03),
        .fns04_o (fns04),
        .fns05_o (fns05),
        .fns06_o (fns06),
        .done_o  (fns_done)
    );

    // datain_q always holds the chunk the coder samples next; in_ready opens only
    // once the final chunk is on the bus, so a new word can follow without a gap.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        datain_d     = datain_q;
        shreg_d      = shreg_q;
        issue_v_d    = 1'b0;
        issue_last_d = 1'b0;
        in_ready     = 1'b0;
        unique case (state_q)
            INIT: begin
                datain_d = '0;
                if (fns_done) state_d = IDLE;
            end
            IDLE: begin
                in_ready = 1'b1;
                datain_d = '0;
            end
            SEND: begin
                if (cnt_q == LAST) begin
                    in_ready = 1'b1;
                    datain_d = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d        = cnt_q + IW'(1);
                    datain_d     = shreg_q[BLEN-1:0];
                    shreg_d      = shreg_q >> BLEN;
                    issue_v_d    = 1'b1;
                    issue_last_d = (cnt_d == LAST);
                end
            end
            default: state_d = INIT;
        endcase
        if (in_ready && bus.in_valid) begin
            state_d      = SEND;
            cnt_d        = '0;
            datain_d     = bus.in_data[BLEN-1:0];
            shreg_d      = bus.in_data >> BLEN;
            issue_v_d    = 1'b1;
            issue_last_d = (CHUNKS == 1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            datain_q     <= '0;
            issue_v_q    <= 1'b0;
            issue_last_q <= 1'b0;
            code_valid_q <= 1'b0;
            code_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            datain_q     <= datain_d;
            issue_v_q    <= issue_v_d;
            issue_last_q <= issue_last_d;
            code_valid_q <= issue_v_q;
            code_last_q  <= issue_last_q;
        end
    end

    always_ff @(posedge clock_i) begin
        shreg_q <= shreg_d;
    end

    assign bus.in_ready     = in_ready;
    assign bus.coder_datain = datain_q;
    assign bus.fns02        = fns02;
    assign bus.fns03        = fns03;
    assign bus.fns04        = fns04;
    assign bus.fns05        = fns05;
    assign bus.fns06        = fns06;
    assign bus.code_out     = bus.coder_codeout;
    assign bus.code_valid   = code_valid_q;
    assign bus.code_last    = code_last_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cac_tx_sequencer.sv
// Directed bench for cac_tx_sequencer with a behavioural registered FNS coder.
module tb_cac_tx_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [5:0] coder_q;

    cac_tx_sequencer_if #(.BLEN(4), .CHUNKS(4), .FNSLEN(5)) bus ();

    cac_tx_sequencer #(.BLEN(4), .CHUNKS(4), .FNSLEN(5)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Greedy Fibonacci encoding with the weights the sequencer supplies.
    function automatic logic [5:0] coder_enc(input logic [3:0] d,
                                             input logic [4:0] w2, input logic [4:0] w3,
                                             input logic [4:0] w4, input logic [4:0] w5,
                                             input logic [4:0] w6);
        int w [6];
        int rem;
        logic [5:0] cw;
        w[0] = 1; w[1] = int'(w2); w[2] = int'(w3);
        w[3] = int'(w4); w[4] = int'(w5); w[5] = int'(w6);
        rem = int'(d);
        cw  = '0;
        for (int i = 5; i >= 0; i--) begin
            if (rem >= w[i]) begin
                cw[i] = 1'b1;
                rem   = rem - w[i];
            end
        end
        return cw;
    endfunction

    always @(posedge clk) begin
        coder_q <= coder_enc(bus.coder_datain, bus.fns02, bus.fns03,
                             bus.fns04, bus.fns05, bus.fns06);
    end
    assign bus.coder_codeout = coder_q;

    // Hand-computed codewords for chunk values 0..15 (weights 8,5,3,2,1,1).
    logic [5:0] enc_tbl [16];
    initial begin
        enc_tbl[0]  = 6'b000000; enc_tbl[1]  = 6'b000010;
        enc_tbl[2]  = 6'b000100; enc_tbl[3]  = 6'b001000;
        enc_tbl[4]  = 6'b001010; enc_tbl[5]  = 6'b010000;
        enc_tbl[6]  = 6'b010010; enc_tbl[7]  = 6'b010100;
        enc_tbl[8]  = 6'b100000; enc_tbl[9]  = 6'b100010;
        enc_tbl[10] = 6'b100100; enc_tbl[11] = 6'b101000;
        enc_tbl[12] = 6'b101010; enc_tbl[13] = 6'b110000;
        enc_tbl[14] = 6'b110010; enc_tbl[15] = 6'b110100;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the three per-cycle outputs of an in-flight transfer.
    task automatic chk_flow(input string tag, input logic [3:0] din,
                            input logic cv, input logic cl);
        chk({tag, ".datain"}, 32'(bus.coder_datain), 32'(din));
        chk({tag, ".valid"},  32'(bus.code_valid),   32'(cv));
        chk({tag, ".last"},   32'(bus.code_last),    32'(cl));
    endtask

    task automatic chk_code(input string tag, input logic [3:0] chunk);
        chk({tag, ".code_out"}, 32'(bus.code_out), 32'(enc_tbl[chunk]));
    endtask

    task automatic chk_table(input string tag);
        chk({tag, ".fns02"}, 32'(bus.fns02), 32'd1);
        chk({tag, ".fns03"}, 32'(bus.fns03), 32'd2);
        chk({tag, ".fns04"}, 32'(bus.fns04), 32'd3);
        chk({tag, ".fns05"}, 32'(bus.fns05), 32'd5);
        chk({tag, ".fns06"}, 32'(bus.fns06), 32'd8);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset held for two edges
        tick();
        tick();
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        chk_flow("rst", 4'h0, 1'b0, 1'b0);
        chk("rst.busy",  32'(bus.busy),  32'd1);
        chk("rst.fns02", 32'(bus.fns02), 32'd1);
        chk("rst.fns03", 32'(bus.fns03), 32'd0);
        chk("rst.fns06", 32'(bus.fns06), 32'd0);

        // Release; payload offered throughout INIT must wait for IDLE
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hF3A5;
        tick();
        chk("init1.in_ready", 32'(bus.in_ready), 32'd0);
        chk("init1.fns03",    32'(bus.fns03),    32'd2);
        chk_flow("init1", 4'h0, 1'b0, 1'b0);
        tick();
        chk("init2.in_ready", 32'(bus.in_ready), 32'd0);
        chk("init2.fns04",    32'(bus.fns04),    32'd3);
        tick();
        chk("init3.in_ready", 32'(bus.in_ready), 32'd0);
        chk("init3.valid",    32'(bus.code_valid), 32'd0);
        tick();
        chk("init4.in_ready", 32'(bus.in_ready), 32'd1);
        chk("init4.busy",     32'(bus.busy),     32'd0);
        chk("init4.valid",    32'(bus.code_valid), 32'd0);
        chk_table("init4");

        // Single payload F3A5 accepted on first IDLE cycle
        tick();
        chk_flow("p1.t1", 4'h5, 1'b0, 1'b0);
        chk("p1.t1.in_ready", 32'(bus.in_ready), 32'd0);
        chk("p1.t1.busy",     32'(bus.busy),     32'd1);
        bus.in_valid = 1'b0;
        tick();
        chk_flow("p1.t2", 4'hA, 1'b1, 1'b0);
        chk_code("p1.t2", 4'h5);
        tick();
        chk_flow("p1.t3", 4'h3, 1'b1, 1'b0);
        chk_code("p1.t3", 4'hA);
        tick();
        chk_flow("p1.t4", 4'hF, 1'b1, 1'b0);
        chk_code("p1.t4", 4'h3);
        chk("p1.t4.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk_flow("p1.t5", 4'h0, 1'b1, 1'b1);
        chk_code("p1.t5", 4'hF);
        chk("p1.t5.busy", 32'(bus.busy), 32'd0);
        tick();
        chk_flow("p1.t6", 4'h0, 1'b0, 1'b0);

        // Back-to-back 1234 then ABCD, zero-gap
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        tick();
        chk_flow("bb.t1", 4'h4, 1'b0, 1'b0);
        bus.in_data = 16'hABCD;
        tick();
        chk_flow("bb.t2", 4'h3, 1'b1, 1'b0);
        chk_code("bb.t2", 4'h4);
        chk("bb.t2.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk_flow("bb.t3", 4'h2, 1'b1, 1'b0);
        chk_code("bb.t3", 4'h3);
        tick();
        chk_flow("bb.t4", 4'h1, 1'b1, 1'b0);
        chk_code("bb.t4", 4'h2);
        chk("bb.t4.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk_flow("bb.t5", 4'hD, 1'b1, 1'b1);
        chk_code("bb.t5", 4'h1);
        bus.in_valid = 1'b0;
        tick();
        chk_flow("bb.t6", 4'hC, 1'b1, 1'b0);
        chk_code("bb.t6", 4'hD);
        tick();
        chk_flow("bb.t7", 4'hB, 1'b1, 1'b0);
        chk_code("bb.t7", 4'hC);
        tick();
        chk_flow("bb.t8", 4'hA, 1'b1, 1'b0);
        chk_code("bb.t8", 4'hB);
        tick();
        chk_flow("bb.t9", 4'h0, 1'b1, 1'b1);
        chk_code("bb.t9", 4'hA);
        tick();
        chk_flow("bb.t10", 4'h0, 1'b0, 1'b0);

        // Source stall, then a fresh word restarts at chunk 0
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_flow("stall", 4'h0, 1'b0, 1'b0);
            chk("stall.busy", 32'(bus.busy), 32'd0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5A96;
        tick();
        chk_flow("rs.t1", 4'h6, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk_flow("rs.t2", 4'h9, 1'b1, 1'b0);
        chk_code("rs.t2", 4'h6);
        tick();
        chk_flow("rs.t3", 4'hA, 1'b1, 1'b0);
        tick();
        chk_flow("rs.t4", 4'h5, 1'b1, 1'b0);
        tick();
        chk_flow("rs.t5", 4'h0, 1'b1, 1'b1);
        chk_code("rs.t5", 4'h5);
        tick();

        // Reset in the middle of FFFF
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        tick();
        chk_flow("mr.t1", 4'hF, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk_flow("mr.t2", 4'hF, 1'b1, 1'b0);
        chk_code("mr.t2", 4'hF);
        rst = 1'b1;
        tick();
        chk_flow("mr.rst", 4'h0, 1'b0, 1'b0);
        chk("mr.rst.in_ready", 32'(bus.in_ready), 32'd0);
        chk("mr.rst.busy",     32'(bus.busy),     32'd1);
        chk("mr.rst.fns03",    32'(bus.fns03),    32'd0);
        chk("mr.rst.fns06",    32'(bus.fns06),    32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr.init.in_ready", 32'(bus.in_ready), 32'd0);
            chk_flow("mr.init", 4'h0, 1'b0, 1'b0);
        end
        tick();
        chk("mr.idle.in_ready", 32'(bus.in_ready), 32'd1);
        chk_flow("mr.idle", 4'h0, 1'b0, 1'b0);
        chk_table("mr.idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
